snake_sound_sequencer: RTL and testbench
========================================

# snake_sound_sequencer

Event-to-tone sequencer directly downstream of the sound pulse conditioner. It consumes the single-cycle event pulses `goodColl`, `badColl`, `button` and `direction[3:0]`, arbitrates them by fixed priority, and drives a square-wave `speaker` output. Tones are fixed-length, and the bad-collision tone is a two-segment descending pair. The output feeds the board speaker pin directly; `playing` and `tone_id` go to the debug/status logic.

## Interface
- `CNT_W`, 20: width of the half-period and duration counters.
- `HALF_DIR`, 2500: direction-click half-period, in clk cycles.
- `HALF_BTN`, 5000: button tone half-period.
- `HALF_GOOD`, 3000: good-collision tone half-period.
- `HALF_BAD_HI`, 6000: bad-collision first-segment half-period.
- `HALF_BAD_LO`, 12000: bad-collision second-segment half-period.
- `DUR_DIR`, `DUR_BTN`, `DUR_GOOD`, `DUR_BAD`, 100000 each: segment lengths, in clk cycles.
- All HALF_* and DUR_* values must be ≥1 and < 2^CNT_W.

- `clk`  in  1  system clock
- `nRst`  in  1  asynchronous active-low reset
- `goodColl`  in  1  good-collision event pulse
- `badColl`  in  1  bad-collision event pulse
- `button`  in  1  button event pulse
- `direction`  in  4  direction event pulses; any nonzero value is one event
- `speaker`  out  1  square-wave tone, low when silent
- `playing`  out  1  high while any segment is active
- `tone_id`  out  3  0 idle, 1 dir, 2 btn, 3 good, 4 bad-hi, 5 bad-lo

## Operation
- States: IDLE, DIR, BTN, GOOD, BAD1, BAD2. `tone_id` is the state encoding above.
- Priority levels: bad=4, good=3, btn=2, dir=1, idle=0. BAD1 and BAD2 are both level 4.
- Per cycle, the highest-level asserted input is the candidate.
- The candidate is accepted if its level is strictly greater than the current level. Equal or lower levels are ignored; they are not queued.
- Exception: on the final cycle of a GOOD, BTN, DIR or BAD2 segment, any candidate is accepted.
- Accepting an event loads that state's segment:
  - half counter = HALF−1
  - duration counter = DUR−1
  - `speaker` = 1
- Half counter:
  - Decrements each cycle while playing.
  - At 0 it reloads HALF−1 and toggles `speaker`.
  - The period is therefore exactly 2·HALF cycles.
- Duration counter:
  - Decrements each cycle.
  - At 0 the segment ends: BAD1 → BAD2 (reload with the LO half-period, `speaker` = 1); all others → IDLE (`speaker` = 0).
- A bad event during BAD2 is ignored (equal level). The pair is never restarted mid-play.
- In IDLE, `speaker` = 0 and counters hold at 0.

## Timing
- Reset (asynchronous, any time, including mid-tone): state IDLE; `speaker`, `playing` = 0; `tone_id` = 0; counters = 0.
- An event high in cycle k gives `playing` = 1, `speaker` = 1 and the new `tone_id` from cycle k+1.
- A segment lasts exactly DUR cycles of `playing` = 1.
- A bad event gives 2·DUR_BAD contiguous cycles with no gap between segments.
- The BAD1→BAD2 transition restarts the half-period count, so there is no partial carry-over.
- Preemption takes effect the next cycle and fully reloads both counters with `speaker` = 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SOUND_DIR_CLICK_EN` defined: direction events produce the DIR click as specified.
- `SOUND_DIR_CLICK_EN` undefined:
  - `direction` is ignored entirely and the DIR state is unreachable.
  - `tone_id` never equals 1.
  - All other behaviour is unchanged.

## Test plan
Parameters for all scenarios: HALF_GOOD=4, DUR_GOOD=20, HALF_BAD_HI=3, HALF_BAD_LO=6, DUR_BAD=12, HALF_BTN=2, DUR_BTN=10.
- Reset, then 1-cycle `goodColl` pulse → `tone_id` = 3 and `playing` = 1 for exactly 20 cycles; `speaker` pattern is 1111000011110000 then 1111; afterwards IDLE with `speaker` = 0.
- `badColl` pulse → tone_id 4 for 12 cycles with period 6, then tone_id 5 for 12 cycles with period 12, then IDLE. `playing` is high for 24 contiguous cycles.
- `button` at cycle 0, `goodColl` at cycle 5 → `tone_id` switches 2→3 at cycle 6; GOOD then runs its full 20 cycles. Repeat with `button` during GOOD → ignored.
- `goodColl` and `badColl` in the same cycle → BAD1 is selected. `badColl` again during BAD2 → ignored; sequence ends on schedule.
- `button` pulse on the last GOOD cycle → BTN starts the next cycle with no idle gap.
- `nRst` asserted mid-BAD1 → outputs go to 0 immediately. With `SOUND_DIR_CLICK_EN` undefined, `direction` = 4'b0100 → `playing` stays 0.

Source files
------------

// File: rtl/snake_sound_sequencer.sv
// Event-to-tone sequencer: arbitrates collision/button/direction pulses and drives a square-wave speaker.
// Optional feature macro: SOUND_DIR_CLICK_EN enables the direction click tone.
module snake_sound_sequencer #(
   parameter int CNT_W       = 20,
   parameter int HALF_DIR    = 2500,
   parameter int HALF_BTN    = 5000,
   parameter int HALF_GOOD   = 3000,
   parameter int HALF_BAD_HI = 6000,
   parameter int HALF_BAD_LO = 12000,
   parameter int DUR_DIR     = 100000,
   parameter int DUR_BTN     = 100000,
   parameter int DUR_GOOD    = 100000,
   parameter int DUR_BAD     = 100000
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       goodColl,
   input  logic       badColl,
   input  logic       button,
   input  logic [3:0] direction,
   output logic       speaker,
   output logic       playing,
   output logic [2:0] tone_id
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DIR  = 3'd1,
      BTN  = 3'd2,
      GOOD = 3'd3,
      BAD1 = 3'd4,
      BAD2 = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO        = '0;
   localparam logic [CNT_W-1:0] H_DIR_M1    = CNT_W'(HALF_DIR - 1);
   localparam logic [CNT_W-1:0] H_BTN_M1    = CNT_W'(HALF_BTN - 1);
   localparam logic [CNT_W-1:0] H_GOOD_M1   = CNT_W'(HALF_GOOD - 1);
   localparam logic [CNT_W-1:0] H_BAD_HI_M1 = CNT_W'(HALF_BAD_HI - 1);
   localparam logic [CNT_W-1:0] H_BAD_LO_M1 = CNT_W'(HALF_BAD_LO - 1);
   localparam logic [CNT_W-1:0] D_DIR_M1    = CNT_W'(DUR_DIR - 1);
   localparam logic [CNT_W-1:0] D_BTN_M1    = CNT_W'(DUR_BTN - 1);
   localparam logic [CNT_W-1:0] D_GOOD_M1   = CNT_W'(DUR_GOOD - 1);
   localparam logic [CNT_W-1:0] D_BAD_M1    = CNT_W'(DUR_BAD - 1);

   state_t           state;
   state_t           cand_state;
   logic [CNT_W-1:0] half_cnt;
   logic [CNT_W-1:0] dur_cnt;
   logic             dir_evt;
   logic             seg_last;
   logic             accept;

`ifdef SOUND_DIR_CLICK_EN
   assign dir_evt = |direction;
`else
   // Direction clicks are compiled out; the input is deliberately inert.
   assign dir_evt = 1'b0 & (|direction);
`endif

   function automatic logic [2:0] level_of(input state_t s);
      case (s)
         BAD1, BAD2: level_of = 3'd4;
         GOOD:       level_of = 3'd3;
         BTN:        level_of = 3'd2;
         DIR:        level_of = 3'd1;
         default:    level_of = 3'd0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] half_of(input state_t s);
      case (s)
         DIR:     half_of = H_DIR_M1;
         BTN:     half_of = H_BTN_M1;
         GOOD:    half_of = H_GOOD_M1;
         BAD1:    half_of = H_BAD_HI_M1;
         BAD2:    half_of = H_BAD_LO_M1;
         default: half_of = ZERO;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] dur_of(input state_t s);
      case (s)
         DIR:        dur_of = D_DIR_M1;
         BTN:        dur_of = D_BTN_M1;
         GOOD:       dur_of = D_GOOD_M1;
         BAD1, BAD2: dur_of = D_BAD_M1;
         default:    dur_of = ZERO;
      endcase
   endfunction

   // IDLE as a candidate means no event this cycle.
   always_comb begin
      cand_state = IDLE;
      if (badColl)       cand_state = BAD1;
      else if (goodColl) cand_state = GOOD;
      else if (button)   cand_state = BTN;
      else if (dir_evt)  cand_state = DIR;
   end

   // BAD1 is excluded so its final cycle always hands over to BAD2.
   assign seg_last = (dur_cnt == ZERO) &&
                     (state == DIR || state == BTN || state == GOOD || state == BAD2);
   assign accept   = (cand_state != IDLE) &&
                     ((level_of(cand_state) > level_of(state)) || seg_last);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= IDLE;
         half_cnt <= ZERO;
         dur_cnt  <= ZERO;
         speaker  <= 1'b0;
         playing  <= 1'b0;
      end else if (accept) begin
         state    <= cand_state;
         half_cnt <= half_of(cand_state);
         dur_cnt  <= dur_of(cand_state);
         speaker  <= 1'b1;
         playing  <= 1'b1;
      end else if (state != IDLE) begin
         if (dur_cnt == ZERO) begin
            if (state == BAD1) begin
               state    <= BAD2;
               half_cnt <= H_BAD_LO_M1;
               dur_cnt  <= D_BAD_M1;
               speaker  <= 1'b1;
               playing  <= 1'b1;
            end else begin
               state    <= IDLE;
               half_cnt <= ZERO;
               dur_cnt  <= ZERO;
               speaker  <= 1'b0;
               playing  <= 1'b0;
            end
         end else begin
            dur_cnt <= dur_cnt - ONE;
            if (half_cnt == ZERO) begin
               half_cnt <= half_of(state);
               speaker  <= ~speaker;
            end else begin
               half_cnt <= half_cnt - ONE;
            end
         end
      end
   end

   assign tone_id = state;

endmodule

// File: tb/tb_snake_sound_sequencer.sv
// Table-driven self-checking bench for snake_sound_sequencer using short test-plan tone parameters.
module tb_snake_sound_sequencer;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       goodColl = 1'b0;
   logic       badColl = 1'b0;
   logic       button = 1'b0;
   logic [3:0] direction = 4'b0000;
   logic       speaker;
   logic       playing;
   logic [2:0] tone_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       good;
      logic       bad;
      logic       btn;
      logic [3:0] dir;
      logic       spk;
      logic       ply;
      logic [2:0] tone;
   } vec_t;

   vec_t vecs[$];

   snake_sound_sequencer #(
      .CNT_W(20),
      .HALF_DIR(2), .HALF_BTN(2), .HALF_GOOD(4), .HALF_BAD_HI(3), .HALF_BAD_LO(6),
      .DUR_DIR(8), .DUR_BTN(10), .DUR_GOOD(20), .DUR_BAD(12)
   ) dut (
      .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl), .button(button),
      .direction(direction), .speaker(speaker), .playing(playing), .tone_id(tone_id)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic g, input logic b, input logic bt, input logic [3:0] d,
                               input logic s, input logic p, input logic [2:0] t);
      vec_t v;
      v.good = g; v.bad = b; v.btn = bt; v.dir = d;
      v.spk = s; v.ply = p; v.tone = t;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      goodColl  = v.good;
      badColl   = v.bad;
      button    = v.btn;
      direction = v.dir;
   endtask

   task automatic checkOutput(input string name, input logic s, input logic p, input logic [2:0] t);
      checks++;
      if (speaker !== s || playing !== p || tone_id !== t) begin
         errors++;
         $display("[TB] FAIL %s: got spk=%b ply=%b tone=%0d, expected spk=%b ply=%b tone=%0d",
                  name, speaker, playing, tone_id, s, p, t);
      end
   endtask

   initial begin
      logic [19:0] good_pat;
      logic [11:0] hi_pat;
      logic [11:0] lo_pat;
      logic [9:0]  btn_pat;
      logic [7:0]  dir_pat;
      good_pat = 20'b1111_0000_1111_0000_1111;
      hi_pat   = 12'b111_000_111_000;
      lo_pat   = 12'b111111_000000;
      btn_pat  = 10'b11_00_11_00_11;
      dir_pat  = 8'b11_00_11_00;

      // single good tone, then idle
      add(1, 0, 0, 4'd0, good_pat[19], 1, 3'd3);
      for (int j = 1; j < 20; j++) add(0, 0, 0, 4'd0, good_pat[19-j], 1, 3'd3);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);

      // bad pair: hi then lo, contiguous
      add(0, 1, 0, 4'd0, hi_pat[11], 1, 3'd4);
      for (int j = 1; j < 12; j++) add(0, 0, 0, 4'd0, hi_pat[11-j], 1, 3'd4);
      for (int j = 0; j < 12; j++) add(0, 0, 0, 4'd0, lo_pat[11-j], 1, 3'd5);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);

      // button preempted by good; button during good ignored
      for (int j = 0; j < 5; j++) add(j == 0, 0, 0, 4'd0, btn_pat[9-j], 1, 3'd2);
      vecs[vecs.size()-5].good = 1'b0;
      vecs[vecs.size()-5].btn  = 1'b1;
      for (int j = 0; j < 20; j++) add(j == 0, 0, j == 5, 4'd0, good_pat[19-j], 1, 3'd3);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);

      // good+bad together selects bad; bad during BAD2 ignored
      add(1, 1, 0, 4'd0, hi_pat[11], 1, 3'd4);
      for (int j = 1; j < 12; j++) add(0, 0, 0, 4'd0, hi_pat[11-j], 1, 3'd4);
      for (int j = 0; j < 12; j++) add(0, j == 3, 0, 4'd0, lo_pat[11-j], 1, 3'd5);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);

      // button on last good cycle chains straight into BTN
      add(1, 0, 0, 4'd0, good_pat[19], 1, 3'd3);
      for (int j = 1; j < 20; j++) add(0, 0, 0, 4'd0, good_pat[19-j], 1, 3'd3);
      add(0, 0, 1, 4'd0, btn_pat[9], 1, 3'd2);
      for (int j = 1; j < 10; j++) add(0, 0, 0, 4'd0, btn_pat[9-j], 1, 3'd2);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);

`ifdef SOUND_DIR_CLICK_EN
      add(0, 0, 0, 4'b0100, dir_pat[7], 1, 3'd1);
      for (int j = 1; j < 8; j++) add(0, 0, 0, 4'd0, dir_pat[7-j], 1, 3'd1);
      add(0, 0, 0, 4'd0, 0, 0, 3'd0);
`else
      if (dir_pat[7]) begin
         add(0, 0, 0, 4'b0100, 0, 0, 3'd0);
         add(0, 0, 0, 4'b1111, 0, 0, 3'd0);
         add(0, 0, 0, 4'd0, 0, 0, 3'd0);
      end
`endif

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 0, 0, 3'd0);
      nRst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_idle", 0, 0, 3'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].spk, vecs[i].ply, vecs[i].tone);
      end

      // asynchronous reset in the middle of BAD1
      badColl = 1'b1;
      @(posedge clk);
      #1;
      badColl = 1'b0;
      checkOutput("bad1_before_reset", 1, 1, 3'd4);
      @(posedge clk);
      #2;
      nRst = 1'b0;
      #1;
      checkOutput("async_reset_mid_bad1", 0, 0, 3'd0);
      @(posedge clk);
      #1;
      nRst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_after_reset_release", 0, 0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
